regfile_writeback_ctrl: RTL and testbench
=========================================

Name: regfile_writeback_ctrl

Overview:
- Writeback-stage controller for the RISC-V core.
- It is the write-side driver of the register file. It arbitrates ALU results and buffered load results onto the single register-file write port (writeCntrl/writeAd/data).
- A small load-result FIFO absorbs results while the ALU holds the port.
- It exports a pending-write scoreboard mask so issue logic can stall on registers with loads in flight.

Parameters:
- DEPTH, 4, number of load-result FIFO entries (power of two, ≥2).
- PTR_W, 2, log2(DEPTH); width of the FIFO read/write pointers.
- DATA_W, 32, register data width.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- ld_valid  input  1  load result offered.
- ld_rd  input  5  load destination register.
- ld_data  input  DATA_W  load result.
- ld_ready  output  1  FIFO can accept a load this cycle.
- writeCntrl  output  1  register-file write enable (registered).
- writeAd  output  5  register-file write address (registered).
- data  output  DATA_W  register-file write data (registered).
- pend_mask  output  32  bit i = 1 when a valid FIFO entry targets x[i].
- count  output  PTR_W+1  FIFO occupancy, valid and cancelled entries included.

Behaviour:
- Reset (async, any time, mid-operation included):
  - writeCntrl=0, writeAd=0, data=0.
  - FIFO pointers=0, count=0, all entry valid bits=0; pending loads are discarded.
  - ld_ready=1, pend_mask=0.
- ALU write qualifier: "alu_wr" = alu_valid & (alu_rd != 0). alu_valid with alu_rd=0 is ignored entirely.
- Load accept: "ld_acc" = ld_valid & ld_ready.
  - ld_rd != 0: entry {rd, data, valid=1} stored at tail, tail advances mod DEPTH, count+1.
  - ld_rd = 0: handshake completes, nothing stored, count unchanged.
- ld_ready = (count < DEPTH), a function of registered count only. There is no same-cycle pop credit; ld_ready=0 whenever full.
- Cancel: on alu_wr, every valid FIFO entry with rd == alu_rd has its valid bit cleared. The slot stays occupied until popped.
  - ALU results are program-order younger than all already-buffered loads.
  - A load accepted in the same cycle is younger than the ALU result and is NOT cancelled.
- Issue, evaluated each cycle in priority order:
  1. alu_wr: writeCntrl<=1, writeAd<=alu_rd, data<=alu_data. Additionally, if count>0 and the head entry is invalid (including one cancelled this cycle), the head is popped with no write.
  2. else if count>0: head popped. If the head is valid (after this cycle's cancel): writeCntrl<=1, writeAd<=head.rd, data<=head.data. If invalid: writeCntrl<=0.
  3. else: writeCntrl<=0; writeAd/data hold their previous values.
- Pop advances head mod DEPTH and decrements count. Simultaneous push and pop leaves count unchanged.
- Latency:
  - ALU result to writeCntrl: 1 cycle.
  - Load to writeCntrl: at least 2 cycles (accept edge, then pop edge). There is no direct load-to-port bypass, even with the FIFO empty.
- Ordering: FIFO pops strictly in accept order. At most one register-file write per cycle.
- pend_mask: combinational OR of one-hot(rd) over valid entries. Bit 0 is always 0. The bit for an entry clears in the cycle after that entry is popped or cancelled.
- Pointer wrap: tail and head wrap from DEPTH-1 to 0. count distinguishes full from empty.

Test Plan:
- Reset: run traffic, then assert rst mid-cycle → immediately writeCntrl=0, writeAd=0, data=0, count=0, ld_ready=1, pend_mask=0.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle → next edge writeCntrl=1, writeAd=5, data=0xDEADBEEF; the following edge writeCntrl=0, writeAd/data hold.
- Load path: ld rd=3, data=0x00000011 at cycle 0 → after edge 1 pend_mask=0x8, count=1; after edge 2 writeCntrl=1, writeAd=3, data=0x11, pend_mask=0, count=0.
- Full/backpressure:
  - Hold alu_valid=1 (rd=7) and offer loads rd=1..5 → after 4 accepts count=4, ld_ready=0, and the rd=5 load waits.
  - Deassert alu_valid → writes x1, x2, x3, x4 on consecutive cycles; x5 is accepted once count<4 and written afterwards.
- Cancel: load rd=9 data=0x1 buffered while ALU busy, then alu rd=9 data=0xA → pend_mask[9]=0; only one write to x9 occurs (data=0xA); the cancelled head pops with no write and count returns to 0.
- x0 filtering: ld rd=0 accepted and alu rd=0 valid → writeCntrl stays 0, count stays 0, pend_mask stays 0.

Source files
------------

// File: rtl/regfile_writeback_ctrl.sv
// Writeback-stage controller: arbitrates ALU results and buffered load results
// onto the single register-file write port and exports a pending-load mask.
module regfile_writeback_ctrl #(
   parameter int DEPTH  = 4,
   parameter int PTR_W  = 2,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              ld_valid,
   input  logic [4:0]        ld_rd,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              writeCntrl,
   output logic [4:0]        writeAd,
   output logic [DATA_W-1:0] data,
   output logic [31:0]       pend_mask,
   output logic [PTR_W:0]    count
);

   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [4:0]        entryRd    [DEPTH];
   logic [DATA_W-1:0] entryData  [DEPTH];
   logic [DEPTH-1:0]  entryValid;
   logic [DEPTH-1:0]  cancelVec;
   logic [PTR_W-1:0]  headPtr;
   logic [PTR_W-1:0]  tailPtr;

   logic aluWr;
   logic push;
   logic pop;
   logic notEmpty;
   logic headValid;

   assign aluWr    = alu_valid & (alu_rd != 5'd0);
   assign ld_ready = (count < FULL_COUNT);
   assign push     = ld_valid & ld_ready & (ld_rd != 5'd0);
   assign notEmpty = (count != '0);

   // ALU results are younger than every buffered load, so matching entries die.
   genvar gi;
   for (gi = 0; gi < DEPTH; gi++) begin : gCancel
      assign cancelVec[gi] = aluWr & entryValid[gi] & (entryRd[gi] == alu_rd);
   end

   assign headValid = entryValid[headPtr] & ~cancelVec[headPtr];
   // A dead head is retired even while the ALU owns the port.
   assign pop       = notEmpty & (~aluWr | ~headValid);

   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (entryValid[i]) pend_mask[entryRd[i]] = 1'b1;
      end
      pend_mask[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            entryRd[i]   <= '0;
            entryData[i] <= '0;
         end
         entryValid <= '0;
         headPtr    <= '0;
         tailPtr    <= '0;
         count      <= '0;
         writeCntrl <= 1'b0;
         writeAd    <= '0;
         data       <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (push && tailPtr == PTR_W'(i)) begin
               entryValid[i] <= 1'b1;
               entryRd[i]    <= ld_rd;
               entryData[i]  <= ld_data;
            end else if ((pop && headPtr == PTR_W'(i)) || cancelVec[i]) begin
               entryValid[i] <= 1'b0;
            end
         end

         if (push) tailPtr <= tailPtr + 1'b1;
         if (pop)  headPtr <= headPtr + 1'b1;

         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (aluWr) begin
            writeCntrl <= 1'b1;
            writeAd    <= alu_rd;
            data       <= alu_data;
         end else if (notEmpty && headValid) begin
            writeCntrl <= 1'b1;
            writeAd    <= entryRd[headPtr];
            data       <= entryData[headPtr];
         end else begin
            writeCntrl <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Self-checking bench for regfile_writeback_ctrl: a queue of expected port
// writes is filled as stimulus is driven and drained by a write monitor.
module tb_regfile_writeback_ctrl;

   localparam int DEPTH  = 4;
   localparam int PTR_W  = 2;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              rst;
   logic              alu_valid;
   logic [4:0]        alu_rd;
   logic [DATA_W-1:0] alu_data;
   logic              ld_valid;
   logic [4:0]        ld_rd;
   logic [DATA_W-1:0] ld_data;
   logic              ld_ready;
   logic              writeCntrl;
   logic [4:0]        writeAd;
   logic [DATA_W-1:0] data;
   logic [31:0]       pend_mask;
   logic [PTR_W:0]    count;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] d;
   } wrExp_t;

   wrExp_t expQ[$];
   int testsRun  = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   regfile_writeback_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W), .DATA_W(DATA_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_valid  (alu_valid),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .ld_valid   (ld_valid),
      .ld_rd      (ld_rd),
      .ld_data    (ld_data),
      .ld_ready   (ld_ready),
      .writeCntrl (writeCntrl),
      .writeAd    (writeAd),
      .data       (data),
      .pend_mask  (pend_mask),
      .count      (count)
   );

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ldd);
      alu_valid = av;
      alu_rd    = ar;
      alu_data  = ad;
      ld_valid  = lv;
      ld_rd     = lr;
      ld_data   = ldd;
   endtask

   task automatic pushExp(input logic [4:0] rd, input logic [31:0] d);
      wrExp_t e;
      e.rd = rd;
      e.d  = d;
      expQ.push_back(e);
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 20; i++) begin
         if (expQ.size() == 0) break;
         @(negedge clk);
         #1;
      end
      checkVal(tag, 32'(expQ.size()), 32'd0);
      tick();
   endtask

   // One line per register-file write, checked against the expected queue.
   always @(negedge clk) begin
      wrExp_t e;
      if (writeCntrl === 1'b1) begin
         $display("[TB] write x%0d = 0x%08h", writeAd, data);
         if (expQ.size() == 0) begin
            checkVal("unexpected_write", 32'(writeCntrl), 32'd0);
         end else begin
            e = expQ.pop_front();
            checkVal("wr_addr", 32'(writeAd), 32'(e.rd));
            checkVal("wr_data", data, e.d);
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      tick();
      checkVal("rst_wc",    32'(writeCntrl), 32'd0);
      checkVal("rst_wa",    32'(writeAd),    32'd0);
      checkVal("rst_data",  data,            32'd0);
      checkVal("rst_count", 32'(count),      32'd0);
      checkVal("rst_ready", 32'(ld_ready),   32'd1);
      checkVal("rst_pend",  pend_mask,       32'd0);
      rst = 1'b0;
      tick();

      // ALU path: one-cycle latency, then address/data hold
      drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0);
      pushExp(5'd5, 32'hDEADBEEF);
      tick();
      checkVal("alu_wc",   32'(writeCntrl), 32'd1);
      checkVal("alu_wa",   32'(writeAd),    32'd5);
      checkVal("alu_data", data,            32'hDEADBEEF);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      checkVal("alu_idle_wc",   32'(writeCntrl), 32'd0);
      checkVal("alu_hold_wa",   32'(writeAd),    32'd5);
      checkVal("alu_hold_data", data,            32'hDEADBEEF);

      // Load path: accept edge, then pop edge
      drive(0, 5'd0, 32'd0, 1, 5'd3, 32'h11);
      pushExp(5'd3, 32'h11);
      tick();
      checkVal("ld_pend1",  pend_mask,       32'h8);
      checkVal("ld_count1", 32'(count),      32'd1);
      checkVal("ld_wc1",    32'(writeCntrl), 32'd0);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      checkVal("ld_wc2",    32'(writeCntrl), 32'd1);
      checkVal("ld_wa2",    32'(writeAd),    32'd3);
      checkVal("ld_data2",  data,            32'h11);
      checkVal("ld_pend2",  pend_mask,       32'd0);
      checkVal("ld_count2", 32'(count),      32'd0);

      // Backpressure: ALU holds the port while loads fill the FIFO
      for (int c = 0; c < 4; c++) begin
         drive(1, 5'd7, 32'h700 + 32'(c), 1, 5'(c + 1), 32'h100 + 32'(c + 1));
         checkVal("bp_ready", 32'(ld_ready), 32'd1);
         pushExp(5'd7, 32'h700 + 32'(c));
         tick();
      end
      checkVal("bp_full_count", 32'(count),    32'd4);
      checkVal("bp_full_ready", 32'(ld_ready), 32'd0);
      checkVal("bp_full_pend",  pend_mask,     32'h1E);
      drive(1, 5'd7, 32'h704, 1, 5'd5, 32'h105);
      pushExp(5'd7, 32'h704);
      tick();
      checkVal("bp_wait_count", 32'(count),    32'd4);
      checkVal("bp_wait_ready", 32'(ld_ready), 32'd0);
      for (int i = 1; i <= 5; i++) pushExp(5'(i), 32'h100 + 32'(i));
      drive(0, 5'd0, 32'd0, 1, 5'd5, 32'h105);
      tick();
      checkVal("bp_pop1_count", 32'(count),    32'd3);
      checkVal("bp_pop1_ready", 32'(ld_ready), 32'd1);
      checkVal("bp_pop1_wa",    32'(writeAd),  32'd1);
      tick();
      checkVal("bp_acc_count",  32'(count),    32'd3);
      checkVal("bp_pop2_wa",    32'(writeAd),  32'd2);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      drain("bp_drain");
      checkVal("bp_end_count", 32'(count), 32'd0);
      checkVal("bp_end_pend",  pend_mask,  32'd0);

      // Cancel of the head entry while the ALU writes the same register
      drive(1, 5'd7, 32'h77, 1, 5'd9, 32'h1);
      pushExp(5'd7, 32'h77);
      tick();
      checkVal("cx_pend9",  pend_mask,  32'h200);
      checkVal("cx_count1", 32'(count), 32'd1);
      drive(1, 5'd9, 32'hA, 0, 5'd0, 32'd0);
      pushExp(5'd9, 32'hA);
      tick();
      checkVal("cx_pend0",  pend_mask,       32'd0);
      checkVal("cx_count0", 32'(count),      32'd0);
      checkVal("cx_wc",     32'(writeCntrl), 32'd1);
      checkVal("cx_wa",     32'(writeAd),    32'd9);
      checkVal("cx_data",   data,            32'hA);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      checkVal("cx_idle_wc", 32'(writeCntrl), 32'd0);

      // Cancel of a non-head entry; same-cycle load to that register survives
      drive(1, 5'd7, 32'h78, 1, 5'd12, 32'hC1);
      pushExp(5'd7, 32'h78);
      tick();
      drive(1, 5'd7, 32'h79, 1, 5'd13, 32'hD1);
      pushExp(5'd7, 32'h79);
      tick();
      checkVal("cy_count2", 32'(count), 32'd2);
      checkVal("cy_pend2",  pend_mask,  32'h3000);
      drive(1, 5'd13, 32'hD2, 1, 5'd13, 32'hD3);
      pushExp(5'd13, 32'hD2);
      tick();
      checkVal("cy_count3", 32'(count), 32'd3);
      checkVal("cy_pend3",  pend_mask,  32'h3000);
      pushExp(5'd12, 32'hC1);
      pushExp(5'd13, 32'hD3);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      tick();
      checkVal("cy_pop12_wa",    32'(writeAd), 32'd12);
      checkVal("cy_pop12_count", 32'(count),   32'd2);
      tick();
      checkVal("cy_dead_wc",    32'(writeCntrl), 32'd0);
      checkVal("cy_dead_count", 32'(count),      32'd1);
      checkVal("cy_dead_pend",  pend_mask,       32'h2000);
      tick();
      checkVal("cy_last_wc",    32'(writeCntrl), 32'd1);
      checkVal("cy_last_wa",    32'(writeAd),    32'd13);
      checkVal("cy_last_data",  data,            32'hD3);
      checkVal("cy_last_count", 32'(count),      32'd0);

      // x0 filtering on both sources
      drive(1, 5'd0, 32'h55, 1, 5'd0, 32'h66);
      checkVal("x0_ready", 32'(ld_ready), 32'd1);
      tick();
      checkVal("x0_wc1",    32'(writeCntrl), 32'd0);
      checkVal("x0_count1", 32'(count),      32'd0);
      checkVal("x0_pend1",  pend_mask,       32'd0);
      checkVal("x0_hold_wa", 32'(writeAd),   32'd13);
      tick();
      checkVal("x0_wc2",    32'(writeCntrl), 32'd0);
      checkVal("x0_count2", 32'(count),      32'd0);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);

      // Asynchronous reset in the middle of a cycle with loads pending
      drive(1, 5'd7, 32'h7A, 1, 5'd20, 32'h201);
      pushExp(5'd7, 32'h7A);
      tick();
      drive(1, 5'd7, 32'h7B, 1, 5'd21, 32'h202);
      pushExp(5'd7, 32'h7B);
      tick();
      checkVal("mr_pre_count", 32'(count), 32'd2);
      checkVal("mr_pre_pend",  pend_mask,  32'h300000);
      drive(0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkVal("mr_wc",    32'(writeCntrl), 32'd0);
      checkVal("mr_wa",    32'(writeAd),    32'd0);
      checkVal("mr_data",  data,            32'd0);
      checkVal("mr_count", 32'(count),      32'd0);
      checkVal("mr_ready", 32'(ld_ready),   32'd1);
      checkVal("mr_pend",  pend_mask,       32'd0);
      tick();
      rst = 1'b0;
      tick();
      tick();
      checkVal("mr_after_wc",    32'(writeCntrl), 32'd0);
      checkVal("mr_after_count", 32'(count),      32'd0);
      checkVal("final_queue",    32'(expQ.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
